// File: rtl/dac_scan_ctrl_pkg.sv
// Shared types, frame constants and the DAC frame builder for the scan controller.
package dac_scan_pkg;

    localparam int         FRAME_W   = 16;
    localparam logic [1:0] PD_NORMAL = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SYNC_SETUP,
        SHIFT,
        SYNC_HI,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_SHIFT,
        TX_HI
    } tx_phase_t;

    // Left-justify a right-aligned code of data_w bits into the 12-bit DAC field.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [11:0] code, input int data_w);
        logic [11:0] field;
        field = code << (12 - data_w);
        return {2'b00, PD_NORMAL, field};
    endfunction

endpackage

// File: rtl/dac_scan_ctrl_if.sv
// Shadow-register write port from the UART register decoder.
interface dac_scan_ctrl_if #(
    parameter int CH_N   = 8,
    parameter int DATA_W = 12
);
    logic                    wr_en;
    logic [$clog2(CH_N)-1:0] wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    commit;

    modport master (output wr_en, wr_addr, wr_data, commit);
    modport slave  (input  wr_en, wr_addr, wr_data, commit);
endinterface

// File: rtl/dac_scan_ctrl_spi_frame_tx.sv
// 16-bit MSB-first SPI frame shifter: setup, 16 bits of 2*SCLK_DIV cycles, sync-high tail.
module spi_frame_tx
    import dac_scan_pkg::*;
#(
    parameter int SCLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame,
    output logic               done,
    output logic               sclk,
    output logic               dout,
    output logic               sync_n
);
    localparam int            CW        = $clog2(2 * SCLK_DIV + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_DIV - 1);
    localparam logic [CW-1:0] LOW_START = CW'(SCLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(2 * SCLK_DIV - 1);

    tx_phase_t          phase, phase_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [3:0]         bit_idx, bit_nxt;
    logic [FRAME_W-1:0] shreg, shreg_nxt;
    logic               sclk_nxt, dout_nxt, sync_n_nxt, framing;

    // Next phase/counters, and pin values for the coming cycle so the pins are registered.
    always_comb begin
        // NOTE: every variable gets a default first; a path that skips an assignment would infer a latch.
        phase_nxt = phase;
        cnt_nxt   = cnt + CW'(1);
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        done      = 1'b0;
        case (phase)
            TX_IDLE: begin
                cnt_nxt = '0;
                if (start) begin
                    phase_nxt = TX_SETUP;
                    shreg_nxt = frame;
                end
            end
            TX_SETUP: if (cnt == HALF_LAST) begin
                phase_nxt = TX_SHIFT;
                cnt_nxt   = '0;
            end
            TX_SHIFT: if (cnt == BIT_LAST) begin
                cnt_nxt = '0;
                if (bit_idx == 4'd15) begin
                    phase_nxt = TX_HI;
                    bit_nxt   = '0;
                end else begin
                    bit_nxt   = bit_idx + 4'd1;
                    shreg_nxt = shreg << 1;
                end
            end
            TX_HI: if (cnt == HALF_LAST) begin
                phase_nxt = TX_IDLE;
                cnt_nxt   = '0;
                done      = 1'b1;
            end
            default: phase_nxt = TX_IDLE;
        endcase
        framing    = (phase_nxt == TX_SETUP) || (phase_nxt == TX_SHIFT);
        sclk_nxt   = !((phase_nxt == TX_SHIFT) && (cnt_nxt >= LOW_START));
        sync_n_nxt = !framing;
        dout_nxt   = framing && shreg_nxt[FRAME_W-1];
    end

    // Phase, counters, shift register and registered SPI pins.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            phase   <= TX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            sclk    <= 1'b1;
            sync_n  <= 1'b1;
            dout    <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            shreg   <= shreg_nxt;
            sclk    <= sclk_nxt;
            sync_n  <= sync_n_nxt;
            dout    <= dout_nxt;
        end
    end

endmodule

// File: rtl/dac_scan_ctrl.sv
// Multi-channel DAC refresh scanner: channel sequencing, shadow/active commit and slot timing.
module dac_scan_ctrl
    import dac_scan_pkg::*;
#(
    parameter int CH_N       = 8,
    parameter int DATA_W     = 12,
    parameter int SCLK_DIV   = 4,
    parameter int SETTLE_CYC = 16,
    parameter int HOLD_CYC   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    input  logic [CH_N-1:0]         ch_en,
    dac_scan_ctrl_if.slave          wr,
    output logic                    sclk,
    output logic                    dout,
    output logic                    sync_n,
    output logic [$clog2(CH_N)-1:0] pos,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    scan_done
);
    localparam int ADDR_W    = $clog2(CH_N);
    localparam int SHIFT_CYC = 32 * SCLK_DIV;
    localparam int TMAX_A    = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int TMAX      = (TMAX_A > SHIFT_CYC) ? TMAX_A : SHIFT_CYC;
    localparam int TW        = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] SETUP_LAST  = TW'(SCLK_DIV - 1);
    localparam logic [TW-1:0] SHIFT_LAST  = TW'(SHIFT_CYC - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYC - 1);

    state_t             state, state_nxt;
    logic [TW-1:0]      timer;
    logic [CH_N-1:0]    en_q;
    logic [DATA_W-1:0]  shadow [CH_N];
    logic [DATA_W-1:0]  active [CH_N];
    logic               pending;
    logic               scan_go, step, tx_start, tx_done;
    logic               nxt_found;
    logic [ADDR_W-1:0]  nxt_idx, first_idx;
    logic [FRAME_W-1:0] frame;

    assign busy  = (state != IDLE);
    assign frame = build_frame(12'(active[pos]), DATA_W);

    // Lowest enabled channel for a scan start, and next higher channel within the latched enables.
    always_comb begin
        first_idx = '0;
        nxt_idx   = '0;
        nxt_found = 1'b0;
        for (int i = CH_N - 1; i >= 0; i--) begin
            if (ch_en[i]) first_idx = ADDR_W'(i);
            if (en_q[i] && (i > int'(pos))) begin
                nxt_idx   = ADDR_W'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // Scan FSM next state and slot pulses.
    always_comb begin
        state_nxt  = state;
        scan_go    = 1'b0;
        step       = 1'b0;
        tx_start   = 1'b0;
        frame_done = 1'b0;
        scan_done  = 1'b0;
        case (state)
            IDLE: if (run && (|ch_en)) begin
                state_nxt = SELECT;
                scan_go   = 1'b1;
            end
            SELECT: if (timer == SETTLE_LAST) begin
                state_nxt = SYNC_SETUP;
                tx_start  = 1'b1;
            end
            SYNC_SETUP: if (timer == SETUP_LAST) state_nxt = SHIFT;
            SHIFT:      if (timer == SHIFT_LAST) state_nxt = SYNC_HI;
            SYNC_HI:    if (tx_done) state_nxt = HOLD;
            HOLD: if (timer == HOLD_LAST) begin
                frame_done = 1'b1;
                scan_done  = !nxt_found;
                if (!run) begin
                    state_nxt = IDLE;
                end else if (nxt_found) begin
                    state_nxt = SELECT;
                    step      = 1'b1;
                end else if (|ch_en) begin
                    state_nxt = SELECT;
                    scan_go   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, phase timer, mux select, latched enables and commit-pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            pos     <= '0;
            en_q    <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= (state_nxt != state) ? '0 : timer + TW'(1);
            if (scan_go) begin
                en_q <= ch_en;
                pos  <= first_idx;
            end else if (step) begin
                pos  <= nxt_idx;
            end
            if (scan_go)        pending <= 1'b0;
            else if (wr.commit) pending <= 1'b1;
        end
    end

    // Shadow registers written from the register decoder; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        // NOTE: these small register files must read as zero after reset, so each entry is cleared explicitly.
        if (rst) begin
            for (int i = 0; i < CH_N; i++) shadow[i] <= '0;
        end else if (wr.wr_en && (int'(wr.wr_addr) < CH_N)) begin
            shadow[wr.wr_addr] <= wr.wr_data;
        end
    end

    // Atomic shadow->active copy at scan start, forwarding a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH_N; i++) active[i] <= '0;
        end else if (scan_go && (pending || wr.commit)) begin
            for (int i = 0; i < CH_N; i++)
                active[i] <= (wr.wr_en && (int'(wr.wr_addr) == i)) ? wr.wr_data : shadow[i];
        end
    end

    spi_frame_tx #(.SCLK_DIV(SCLK_DIV)) u_tx (
        .clk    (clk),
        .rst    (rst),
        .start  (tx_start),
        .frame  (frame),
        .done   (tx_done),
        .sclk   (sclk),
        .dout   (dout),
        .sync_n (sync_n)
    );

endmodule

// File: tb/tb_dac_scan_ctrl.sv
// Directed bench for dac_scan_ctrl: 8-channel main instance plus a 9-channel instance for address range.
module tb_dac_scan_ctrl;

    localparam int SLOT = 80;

    typedef struct {
        logic [3:0]  p;
        int          low;
        logic [15:0] word;
        int          nbits;
        int          fd_cyc;
        int          fd_cnt;
        logic        sd;
        int          sd_cyc;
    } slot_t;

    logic       clk = 1'b0;
    logic       rst, run, run9, sel;
    logic [7:0] ch_en;
    logic [8:0] ch_en9;
    logic       sclk, dout, sync_n, busy, frame_done, scan_done;
    logic [2:0] pos;
    logic       sclk9, dout9, sync_n9, busy9, frame_done9, scan_done9;
    logic [3:0] pos9;
    logic       m_sclk, m_dout, m_sync_n, m_busy, m_frame_done, m_scan_done;
    logic [3:0] m_pos;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;
    slot_t      r;

    always #5 clk = ~clk;

    dac_scan_ctrl_if #(.CH_N(8), .DATA_W(12)) wr_a ();
    dac_scan_ctrl_if #(.CH_N(9), .DATA_W(12)) wr_b ();

    dac_scan_ctrl #(.CH_N(8), .DATA_W(12), .SCLK_DIV(2), .SETTLE_CYC(4), .HOLD_CYC(8)) dut (
        .clk(clk), .rst(rst), .run(run), .ch_en(ch_en), .wr(wr_a),
        .sclk(sclk), .dout(dout), .sync_n(sync_n), .pos(pos), .busy(busy),
        .frame_done(frame_done), .scan_done(scan_done)
    );

    dac_scan_ctrl #(.CH_N(9), .DATA_W(12), .SCLK_DIV(2), .SETTLE_CYC(4), .HOLD_CYC(8)) dut9 (
        .clk(clk), .rst(rst), .run(run9), .ch_en(ch_en9), .wr(wr_b),
        .sclk(sclk9), .dout(dout9), .sync_n(sync_n9), .pos(pos9), .busy(busy9),
        .frame_done(frame_done9), .scan_done(scan_done9)
    );

    assign m_sclk       = sel ? sclk9 : sclk;
    assign m_dout       = sel ? dout9 : dout;
    assign m_sync_n     = sel ? sync_n9 : sync_n;
    assign m_busy       = sel ? busy9 : busy;
    assign m_frame_done = sel ? frame_done9 : frame_done;
    assign m_scan_done  = sel ? scan_done9 : scan_done;
    assign m_pos        = sel ? pos9 : {1'b0, pos};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [2:0] a, input logic [11:0] d);
        wr_a.wr_en = 1'b1; wr_a.wr_addr = a; wr_a.wr_data = d;
        tick();
        wr_a.wr_en = 1'b0;
    endtask

    task automatic write_b(input logic [3:0] a, input logic [11:0] d);
        wr_b.wr_en = 1'b1; wr_b.wr_addr = a; wr_b.wr_data = d;
        tick();
        wr_b.wr_en = 1'b0;
    endtask

    task automatic commit_pulse();
        if (sel) wr_b.commit = 1'b1; else wr_a.commit = 1'b1;
        tick();
        wr_a.commit = 1'b0;
        wr_b.commit = 1'b0;
    endtask

    // Advance until busy rises (first cycle of the first slot), bounded.
    task automatic wait_start(input string tag);
        int n = 0;
        while (!m_busy && n < 200) begin
            tick();
            n++;
        end
        check({tag, ".start"}, {31'd0, m_busy}, 32'd1);
    endtask

    // Observe one 80-cycle slot from its first cycle; optionally act at cycle act_cyc:
    // 1 = write shadow[2]=0x123, 2 = commit pulse, 3 = drop run.
    task automatic run_slot(input int act_cyc, input int act, output slot_t s);
        logic prev_sclk = 1'b1;
        s.p = m_pos; s.low = 0; s.word = '0; s.nbits = 0;
        s.fd_cyc = 0; s.fd_cnt = 0; s.sd = 1'b0; s.sd_cyc = 0;
        for (int i = 1; i <= SLOT; i++) begin
            if (!m_sync_n) s.low++;
            if (prev_sclk && !m_sclk) begin
                s.word = {s.word[14:0], m_dout};
                s.nbits++;
            end
            prev_sclk = m_sclk;
            if (m_frame_done) begin s.fd_cnt++; s.fd_cyc = i; end
            if (m_scan_done)  begin s.sd = 1'b1; s.sd_cyc = i; end
            if (i == act_cyc) begin
                case (act)
                    1: begin wr_a.wr_en = 1'b1; wr_a.wr_addr = 3'd2; wr_a.wr_data = 12'h123; end
                    2: wr_a.commit = 1'b1;
                    3: if (sel) run9 = 1'b0; else run = 1'b0;
                    default: ;
                endcase
            end else if (i == act_cyc + 1) begin
                wr_a.wr_en  = 1'b0;
                wr_a.commit = 1'b0;
            end
            tick();
        end
    endtask

    task automatic check_slot(input string tag, input slot_t s, input int p, input logic [15:0] w, input logic sd);
        check({tag, ".pos"},   32'(s.p), 32'(p));
        check({tag, ".word"},  32'(s.word), 32'(w));
        check({tag, ".nbits"}, 32'(s.nbits), 32'd16);
        check({tag, ".low"},   32'(s.low), 32'd66);
        check({tag, ".fd"},    32'(s.fd_cyc), 32'd80);
        check({tag, ".fdcnt"}, 32'(s.fd_cnt), 32'd1);
        check({tag, ".sd"},    {31'd0, s.sd}, {31'd0, sd});
        if (sd) check({tag, ".sdcyc"}, 32'(s.sd_cyc), 32'd80);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int any_busy;
        int any_low;
        sel = 1'b0; rst = 1'b1; run = 1'b0; run9 = 1'b0; ch_en = '0; ch_en9 = '0;
        wr_a.wr_en = 1'b0; wr_a.wr_addr = '0; wr_a.wr_data = '0; wr_a.commit = 1'b0;
        wr_b.wr_en = 1'b0; wr_b.wr_addr = '0; wr_b.wr_data = '0; wr_b.commit = 1'b0;
        tick();
        tick();
        check("rst.sclk",   {31'd0, sclk},   32'd1);
        check("rst.sync_n", {31'd0, sync_n}, 32'd1);
        check("rst.dout",   {31'd0, dout},   32'd0);
        check("rst.pos",    32'(pos),        32'd0);
        check("rst.busy",   {31'd0, busy},   32'd0);
        check("rst.pulses", {30'd0, frame_done, scan_done}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single channel 3 carrying 0xABC
        write_a(3'd3, 12'hABC);
        commit_pulse();
        ch_en = 8'h08;
        run = 1'b1;
        wait_start("t1");
        ch_en = 8'hA5;
        run_slot(0, 0, r);
        check_slot("t1", r, 3, 16'h0ABC, 1'b1);

        // 2/3: scan 0,2,5,7; uncommitted write to shadow[2] during channel 2's SHIFT
        run_slot(0, 0, r);  check_slot("t2.c0", r, 0, 16'h0000, 1'b0);
        run_slot(30, 1, r); check_slot("t2.c2", r, 2, 16'h0000, 1'b0);
        run_slot(0, 0, r);  check_slot("t2.c5", r, 5, 16'h0000, 1'b0);
        run_slot(0, 0, r);  check_slot("t2.c7", r, 7, 16'h0000, 1'b1);
        run_slot(0, 0, r);  check_slot("t3.c0", r, 0, 16'h0000, 1'b0);
        run_slot(0, 0, r);  check_slot("t3.c2", r, 2, 16'h0000, 1'b0);
        run_slot(40, 2, r); check_slot("t3.c5", r, 5, 16'h0000, 1'b0);
        run_slot(0, 0, r);  check_slot("t3.c7", r, 7, 16'h0000, 1'b1);
        run_slot(0, 0, r);  check_slot("t3.n0", r, 0, 16'h0000, 1'b0);

        // 4: drop run during channel 2's SHIFT; slot completes, then IDLE
        run_slot(30, 3, r); check_slot("t4.c2", r, 2, 16'h0123, 1'b0);
        check("t4.busy",   {31'd0, busy},   32'd0);
        check("t4.sclk",   {31'd0, sclk},   32'd1);
        check("t4.sync_n", {31'd0, sync_n}, 32'd1);
        check("t4.pos",    32'(pos),        32'd2);
        repeat (10) tick();
        check("t4.idle",   {31'd0, busy},   32'd0);
        check("t4.pos2",   32'(pos),        32'd2);

        // 5: reset mid-SHIFT, then committed zeros go out
        ch_en = 8'h08;
        run = 1'b1;
        wait_start("t5a");
        repeat (19) tick();
        rst = 1'b1;
        run = 1'b0;
        tick();
        check("t5.sclk",   {31'd0, sclk},   32'd1);
        check("t5.sync_n", {31'd0, sync_n}, 32'd1);
        check("t5.pos",    32'(pos),        32'd0);
        check("t5.busy",   {31'd0, busy},   32'd0);
        rst = 1'b0;
        tick();
        commit_pulse();
        run = 1'b1;
        wait_start("t5b");
        run_slot(10, 3, r); check_slot("t5.c3", r, 3, 16'h0000, 1'b1);
        check("t5.end", {31'd0, busy}, 32'd0);

        // 6: run with no channels enabled stays idle
        ch_en = 8'h00;
        run = 1'b1;
        any_busy = 0;
        any_low = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) any_busy = 1;
            if (!sync_n) any_low = 1;
        end
        check("t6.busy", 32'(any_busy), 32'd0);
        check("t6.sync", 32'(any_low),  32'd0);
        run = 1'b0;

        // 6: out-of-range addresses on the 9-channel instance (4-bit address)
        sel = 1'b1;
        write_b(4'd9,  12'hFFF);
        write_b(4'd8,  12'h0F0);
        write_b(4'd15, 12'hFFF);
        commit_pulse();
        ch_en9 = 9'h102;
        run9 = 1'b1;
        wait_start("t6b");
        run_slot(0, 0, r);  check_slot("t6.c1", r, 1, 16'h0000, 1'b0);
        run_slot(10, 3, r); check_slot("t6.c8", r, 8, 16'h00F0, 1'b1);
        check("t6.end", {31'd0, busy9}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
